// File: rtl/bus_master_arbiter_pkg.sv
// Shared types and defaults for the bus master arbiter.
//   arb_state_e        : bus hand-over FSM states
//   DEFAULT_CHANNELS   : default number of DMA requesters
//   DEFAULT_PAGE_WIDTH : default page register width
package bus_master_arbiter_pkg;
  localparam int DEFAULT_CHANNELS   = 4;
  localparam int DEFAULT_PAGE_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ACK,
    ST_WAIT,
    ST_GRANT,
    ST_RELEASE
  } arb_state_e;
endpackage

// File: rtl/rotating_priority_encoder.sv
// Picks one requester. Fixed mode scans from index 0; rotating mode scans
// from pointer upward, wrapping at CHANNELS.
//   request : request vector, bit i = channel i
//   pointer : first index to consider in rotating mode
//   rotate  : 0 = fixed, 1 = rotating
//   winner  : selected index (0 when nothing requested)
//   valid   : at least one request present
module rotating_priority_encoder #(
  parameter  int CHANNELS = 4,
  localparam int IW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] request,
  input  logic [IW-1:0]       pointer,
  input  logic                rotate,
  output logic [IW-1:0]       winner,
  output logic                valid
);
  always_comb begin : scan
    int base;
    int idx;
    winner = '0;
    valid  = 1'b0;
    base   = rotate ? int'(pointer) : 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (base + k) % CHANNELS;
      if (!valid && request[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_master_arbiter.sv
// DMA bus master arbiter: negotiates the bus away from the CPU, grants one
// DMA channel at a time and forms the full address from a per-channel page
// register plus the DMA controller's 16-bit offset.
//   clock, reset_n            : clock, async active-low reset
//   processor_status/lock_n   : CPU bus state; hand-over only when passive+unlocked
//   channel_request           : level requests
//   terminal_count            : ends the current grant
//   rotate_priority           : 0 fixed, 1 rotating priority
//   page_write/select/data    : page register write port
//   dma_offset                : low 16 address bits
//   channel_grant_n           : active-low one-hot grant
//   hold_acknowledge          : CPU has released the bus
//   address_enable_n          : high disables CPU address/command drivers
//   dma_wait_n                : low during the single wait cycle
//   address, active_channel   : granted address / channel, 0 when idle
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter  int CHANNELS   = DEFAULT_CHANNELS,
  parameter  int PAGE_WIDTH = DEFAULT_PAGE_WIDTH,
  localparam int IW         = $clog2(CHANNELS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             processor_status,
  input  logic                   processor_lock_n,
  input  logic [CHANNELS-1:0]    channel_request,
  input  logic                   terminal_count,
  input  logic                   rotate_priority,
  input  logic                   page_write,
  input  logic [IW-1:0]          page_select,
  input  logic [PAGE_WIDTH-1:0]  page_data,
  input  logic [15:0]            dma_offset,
  output logic [CHANNELS-1:0]    channel_grant_n,
  output logic                   hold_acknowledge,
  output logic                   address_enable_n,
  output logic                   dma_wait_n,
  output logic [16+PAGE_WIDTH-1:0] address,
  output logic [IW-1:0]          active_channel
);
  arb_state_e                         state_q, state_d;
  logic [IW-1:0]                      active_q;
  logic [IW-1:0]                      ptr_q;
  logic [CHANNELS-1:0][PAGE_WIDTH-1:0] page_q;
  logic [IW-1:0]                      win;
  logic                               win_vld;
  logic                               grant_exit;

  rotating_priority_encoder #(.CHANNELS(CHANNELS)) u_enc (
    .request (channel_request),
    .pointer (ptr_q),
    .rotate  (rotate_priority),
    .winner  (win),
    .valid   (win_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|channel_request) state_d = ST_HOLD;
      ST_HOLD: begin
        if (!(|channel_request))
          state_d = ST_IDLE;
        else if (processor_status == 3'b111 && processor_lock_n)
          state_d = ST_ACK;
      end
      ST_ACK:     state_d = ST_WAIT;
      ST_WAIT:    state_d = win_vld ? ST_GRANT : ST_RELEASE;
      // Only the granted channel's own request or terminal count ends a grant.
      ST_GRANT:   if (!channel_request[active_q] || terminal_count) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign grant_exit = (state_q == ST_GRANT) && (state_d != ST_GRANT);

  // Winner is frozen at the WAIT->GRANT edge, so mode changes only affect
  // the next latch. Rotation pointer advances past the channel just served.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      ptr_q    <= '0;
    end else begin
      if (state_q == ST_WAIT && win_vld) active_q <= win;
      if (grant_exit)
        ptr_q <= (active_q == IW'(CHANNELS-1)) ? '0 : active_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) page_q <= '0;
    else if (page_write && (32'(page_select) < CHANNELS)) page_q[page_select] <= page_data;
  end

  always_comb begin
    channel_grant_n  = '1;
    hold_acknowledge = 1'b0;
    address_enable_n = 1'b0;
    dma_wait_n       = 1'b1;
    address          = '0;
    active_channel   = '0;
    case (state_q)
      ST_ACK:  hold_acknowledge = 1'b1;
      ST_WAIT: begin
        hold_acknowledge = 1'b1;
        address_enable_n = 1'b1;
        dma_wait_n       = 1'b0;
      end
      ST_GRANT: begin
        hold_acknowledge          = 1'b1;
        address_enable_n          = 1'b1;
        channel_grant_n[active_q] = 1'b0;
        address                   = {page_q[active_q], dma_offset};
        active_channel            = active_q;
      end
      ST_RELEASE: address_enable_n = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter (CHANNELS=4, PAGE_WIDTH=4).
module tb_bus_master_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic [3:0]  channel_request;
  logic        terminal_count;
  logic        rotate_priority;
  logic        page_write;
  logic [1:0]  page_select;
  logic [3:0]  page_data;
  logic [15:0] dma_offset;
  logic [3:0]  channel_grant_n;
  logic        hold_acknowledge;
  logic        address_enable_n;
  logic        dma_wait_n;
  logic [19:0] address;
  logic [1:0]  active_channel;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_master_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .processor_status(processor_status), .processor_lock_n(processor_lock_n),
    .channel_request(channel_request), .terminal_count(terminal_count),
    .rotate_priority(rotate_priority), .page_write(page_write),
    .page_select(page_select), .page_data(page_data), .dma_offset(dma_offset),
    .channel_grant_n(channel_grant_n), .hold_acknowledge(hold_acknowledge),
    .address_enable_n(address_enable_n), .dma_wait_n(dma_wait_n),
    .address(address), .active_channel(active_channel)
  );

  typedef struct {
    logic [3:0]  req;
    logic [2:0]  st;
    logic        lk;
    logic        tc;
    logic [3:0]  gnt;
    logic        hlda;
    logic        aen;
    logic        wt;
    logic [1:0]  act;
    logic [19:0] addr;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_gnt"},  channel_grant_n, 4'hF);
    check({nm, "_hlda"}, hold_acknowledge, 1'b0);
    check({nm, "_aen"},  address_enable_n, 1'b0);
    check({nm, "_wait"}, dma_wait_n, 1'b1);
    check({nm, "_addr"}, address, 20'h0);
    check({nm, "_act"},  active_channel, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for any grant, then checks it is channel exp.
  task automatic wait_grant(input string nm, input logic [1:0] exp);
    logic [3:0] e;
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (channel_grant_n !== 4'hF) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no grant expected channel %0d", nm, exp);
    end else begin
      e = ~(4'b0001 << exp);
      check({nm, "_gnt"}, channel_grant_n, e);
      check({nm, "_act"}, active_channel, exp);
    end
  endtask

  initial begin
    // req, st, lk, tc, gnt, hlda, aen, wt, act, addr
    // basic ch2 hand-over, E0..E3 latency, release
    vec[0]  = '{4'b0100, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[1]  = '{4'b0100, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[2]  = '{4'b0100, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 20'h0};
    vec[3]  = '{4'b0100, 3'b111, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 2'd2, 20'h01234};
    vec[4]  = '{4'b0100, 3'b111, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 2'd2, 20'h01234};
    vec[5]  = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 20'h0};
    vec[6]  = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    // request dropped during ACK: WAIT -> RELEASE -> IDLE, no grant
    vec[7]  = '{4'b0001, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[8]  = '{4'b0001, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[9]  = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 20'h0};
    vec[10] = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 20'h0};
    vec[11] = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    // CPU busy holds in HOLD; tc and drop together give a single RELEASE
    vec[12] = '{4'b1000, 3'b010, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[13] = '{4'b1000, 3'b010, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[14] = '{4'b1000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[15] = '{4'b1000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 20'h0};
    vec[16] = '{4'b1000, 3'b111, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b1, 2'd3, 20'h01234};
    vec[17] = '{4'b0000, 3'b111, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 20'h0};
    vec[18] = '{4'b0000, 3'b111, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    // HOLD -> IDLE when requests vanish
    vec[19] = '{4'b0010, 3'b010, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};
    vec[20] = '{4'b0000, 3'b010, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0};

    reset_n = 1'b0;
    processor_status = 3'b111;
    processor_lock_n = 1'b1;
    channel_request  = 4'b0;
    terminal_count   = 1'b0;
    rotate_priority  = 1'b0;
    page_write       = 1'b0;
    page_select      = 2'd0;
    page_data        = 4'h0;
    dma_offset       = 16'h1234;
    #2;
    check_idle("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      channel_request  = vec[i].req;
      processor_status = vec[i].st;
      processor_lock_n = vec[i].lk;
      terminal_count   = vec[i].tc;
      step();
      check($sformatf("v%0d_gnt", i),  channel_grant_n,  vec[i].gnt);
      check($sformatf("v%0d_hlda", i), hold_acknowledge, vec[i].hlda);
      check($sformatf("v%0d_aen", i),  address_enable_n, vec[i].aen);
      check($sformatf("v%0d_wait", i), dma_wait_n,       vec[i].wt);
      check($sformatf("v%0d_act", i),  active_channel,   vec[i].act);
      check($sformatf("v%0d_addr", i), address,          vec[i].addr);
    end

    // CPU lock keeps the arbiter in HOLD
    processor_status = 3'b111;
    processor_lock_n = 1'b0;
    channel_request  = 4'b0001;
    for (int n = 0; n < 11; n++) begin
      step();
      check($sformatf("lock%0d_hlda", n), hold_acknowledge, 1'b0);
      check($sformatf("lock%0d_aen", n),  address_enable_n, 1'b0);
    end
    processor_lock_n = 1'b1;
    step();
    check("unlock_hlda", hold_acknowledge, 1'b1);
    check("unlock_aen",  address_enable_n, 1'b0);
    channel_request = 4'b0;
    step(); step(); step();
    check_idle("unlock_end");

    // fixed priority: channel 0 every time
    do_reset();
    rotate_priority = 1'b0;
    channel_request = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("fix%0d", g), 2'd0);
      terminal_count = 1'b1;
      step();
      terminal_count = 1'b0;
    end

    // rotating priority: 0,1,2,3,0 from a fresh pointer
    channel_request = 4'h0;
    rotate_priority = 1'b1;
    do_reset();
    channel_request = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("rot%0d", g), 2'(g % 4));
      terminal_count = 1'b1;
      step();
      terminal_count = 1'b0;
    end

    // page registers and live page update
    channel_request = 4'h0;
    rotate_priority = 1'b0;
    do_reset();
    page_write = 1'b1; page_select = 2'd2; page_data = 4'hA;
    step();
    page_select = 2'd3; page_data = 4'hF;
    step();
    page_write = 1'b0;
    channel_request = 4'b0100;
    wait_grant("page", 2'd2);
    check("page_addr", address, 20'hA1234);
    page_write = 1'b1; page_select = 2'd2; page_data = 4'h5;
    step();
    page_write = 1'b0;
    check("page_live_addr", address, 20'h51234);

    // asynchronous reset mid-grant
    check("pre_rst_gnt", channel_grant_n, 4'hB);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    wait_grant("post_rst", 2'd2);
    check("post_rst_page", address, 20'h01234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
